risc_v_mike_uart_mmio: RTL
==========================

// Module: risc_v_mike_uart_mmio
// PURPOSE
// - Memory-mapped UART front end between the core data bus and one UART_MIKE instance.
// - Replaces raw gpio flag polling with parametrised TX/RX FIFOs, status/control registers and TX/RX sequencers.
// - Software writes bytes to TXDATA and reads them from RXDATA; the block handles tx_send/tx_flag/rx_flag handshakes.
// PARAMETERS
// - DATA_W       8   UART character width (bits), 5..8
// - TX_DEPTH     8   TX FIFO entries, power of 2, >=2
// - RX_DEPTH     8   RX FIFO entries, power of 2, >=2
// - ADDR_W       4   bus byte-address width, word offsets 0x0..0xC
// PORTS
// - clk              in   1       core clock
// - rst              in   1       synchronous reset, active-high
// - bus_addr         in   ADDR_W  byte offset in the peripheral window; bits [1:0] ignored
// - bus_wr           in   1       write strobe, one access per cycle
// - bus_rd           in   1       read strobe; a pop occurs only on RXDATA reads
// - bus_wr_data      in   32      write data
// - bus_rd_data      out  32      combinational read data, valid in the same cycle as bus_rd
// - uart_tx_data     out  DATA_W  character to the UART transmitter
// - uart_tx_send     out  1       one-cycle start pulse
// - uart_tx_flag     in   1       transmitter done (sticky until cleared)
// - uart_tx_flag_clr out  1       one-cycle clear of uart_tx_flag
// - uart_rx_data     in   DATA_W  received character
// - uart_rx_flag     in   1       character received (sticky until cleared)
// - uart_rx_flag_clr out  1       one-cycle clear of uart_rx_flag
// BEHAVIOUR
// - Register map:
//   - 0x0 TXDATA (W): push bus_wr_data[DATA_W-1:0]; if TX full, drop the write and set tx_ovf.
//   - 0x4 RXDATA (R): returns head, zero-extended, and pops; if empty, returns 0, no pop, and sets rx_unf.
//   - 0x8 STATUS (R): [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty [4]tx_busy [5]tx_ovf [6]rx_ovf [7]rx_unf [15:8]rx_count; other bits 0.
//   - 0xC CTRL (W): [0] flush TX, [1] flush RX, [2] clear sticky errors. Self-clearing. Reads return 0.
//   - Unmapped offsets: reads return 0, writes are ignored.
// - FIFOs: registered storage with wrapping read/write pointers plus an extra MSB for full/empty.
//   - Simultaneous push and pop on the same FIFO: the count is unchanged, legal even when full (pop first).
// - TX FSM, states IDLE -> LOAD -> WAIT -> CLR -> IDLE:
//   - IDLE: if TX is not empty, pop the head into the uart_tx_data register, then go to LOAD.
//   - LOAD: uart_tx_send=1 for exactly one cycle, then go to WAIT.
//   - WAIT: stay until uart_tx_flag=1.
//   - CLR: uart_tx_flag_clr=1 for one cycle, then go to IDLE.
//   - tx_busy = (state != IDLE).
//   - Back-to-back characters have 3 cycles of overhead beyond the UART frame.
// - RX FSM, states IDLE -> CAPT -> DRAIN:
//   - IDLE: on uart_rx_flag=1, go to CAPT.
//   - CAPT: push uart_rx_data, or set rx_ovf if full (character lost); uart_rx_flag_clr=1 for one cycle; go to DRAIN.
//   - DRAIN: wait for uart_rx_flag=0, then go to IDLE. This prevents double capture.
// - A CTRL flush in the same cycle as a push or pop: the flush wins, and the FIFO is empty next cycle.
//   - A TX flush does not abort a character already in LOAD/WAIT/CLR.
// - Sticky error bits are set by events and cleared only by CTRL[2] or reset. Set wins over clear in the same cycle.
// - Reset (any cycle, including mid-frame):
//   - FSMs go to IDLE, FIFOs are emptied, error bits are cleared.
//   - uart_tx_data=0, uart_tx_send=0, uart_tx_flag_clr=0, uart_rx_flag_clr=0.
//   - The first post-reset cycle pulses uart_tx_flag_clr and uart_rx_flag_clr once to discard stale UART flags.
// CONFIGURATION
// - RISC_V_MIKE_UART_IRQ_EN defined:
//   - Adds output irq (1b, registered, reset 0) and CTRL bits [3]rx_irq_en, [4]tx_irq_en (reset 0, persistent).
//   - irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & ~tx_busy).
//   - CTRL reads return [4:3]; other bits read 0.
// - Undefined: no irq port, CTRL bits [4:3] are ignored, and CTRL reads are 0.
// TESTING
// - Reset, then read STATUS -> 0x0000_000A (tx_empty, rx_empty). Exactly one uart_tx_flag_clr and one uart_rx_flag_clr pulse.
// - Write 0x41, 0x42 to TXDATA; model raises tx_flag 20 cycles after each send.
//   -> uart_tx_send pulses carry 0x41 then 0x42 in order, each followed by one tx_flag_clr. tx_busy=0 afterwards.
// - Write 9 bytes to TXDATA with DEPTH=8 while the UART is stalled (tx_flag never set)
//   -> the first pops into the FSM, 8 remain queued, the 9th is dropped only if full, and tx_ovf follows the full flag exactly.
// - Inject 9 RX characters 0x10..0x18 without reading -> rx_count=8, rx_ovf=1, and RXDATA reads return 0x10..0x17, then 0 with rx_unf=1.
// - Push RXDATA read and RX capture in the same cycle while full -> count stays 8, no rx_ovf. Then CTRL=0x3 -> both FIFOs empty next cycle.
// - Assert rst during TX WAIT -> next cycle uart_tx_send=0, tx_busy=0, STATUS=0x0A. With RISC_V_MIKE_UART_IRQ_EN and CTRL=0x08, an RX byte drives irq=1 until it is read.

Source files
------------

// File: rtl/risc_v_mike_uart_mmio.sv
// Memory-mapped UART front end: TX/RX FIFOs, status/control registers and
// TX/RX sequencers that drive the UART_MIKE tx_send/tx_flag/rx_flag handshakes.
// Optional interrupt output is enabled by defining RISC_V_MIKE_UART_IRQ_EN.

// Registered FIFO with wrapping pointers; the extra pointer MSB tells full from empty.
module MikeUartFifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wrPtr_q, wrPtr_d;
  logic [AW:0]       rdPtr_q, rdPtr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              doPush;
  logic              doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o = wrPtr_q - rdPtr_q;
  assign head_o  = mem_q[rdPtr_q[AW-1:0]];

  // A pop frees the head slot first, so a push while full is accepted if a pop happens too
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Pointer update; a flush overrides any push or pop in the same cycle
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

module risc_v_mike_uart_mmio #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [31:0]       bus_wr_data,
  output logic [31:0]       bus_rd_data,
`ifdef RISC_V_MIKE_UART_IRQ_EN
  output logic              irq,
`endif
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_send,
  input  logic              uart_tx_flag,
  output logic              uart_tx_flag_clr,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_flag,
  output logic              uart_rx_flag_clr
);

  localparam logic [ADDR_W-3:0] OFF_TXDATA = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] OFF_RXDATA = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] OFF_STATUS = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] OFF_CTRL   = (ADDR_W-2)'(3);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT, TX_CLR} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_CAPT, RX_DRAIN} rxState_t;

  txState_t txState_q, txState_d;
  rxState_t rxState_q, rxState_d;

  logic [ADDR_W-3:0] wordSel;
  logic txWrReq, rxRdReq, ctrlWr;
  logic txFlush, rxFlush, errClr;
  logic txPop, rxCapt;
  logic [DATA_W-1:0] txHead, rxHead;
  logic txFull, txEmpty, rxFull, rxEmpty;
  logic [$clog2(TX_DEPTH):0] txCount;
  logic [$clog2(RX_DEPTH):0] rxCount;
  logic txBusy;
  logic [DATA_W-1:0] txData_q;
  logic rstSeen_q, startClr;
  logic txOvf_q, rxOvf_q, rxUnf_q;
  logic txOvfSet, rxOvfSet, rxUnfSet;
  logic [31:0] statusWord;
  logic unusedBits;

  assign wordSel = bus_addr[ADDR_W-1:2];
  assign txWrReq = bus_wr & (wordSel == OFF_TXDATA);
  assign rxRdReq = bus_rd & (wordSel == OFF_RXDATA);
  assign ctrlWr  = bus_wr & (wordSel == OFF_CTRL);
  assign txFlush = ctrlWr & bus_wr_data[0];
  assign rxFlush = ctrlWr & bus_wr_data[1];
  assign errClr  = ctrlWr & bus_wr_data[2];
  assign unusedBits = ^{bus_addr[1:0], bus_wr_data[31:DATA_W]};

  MikeUartFifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) txFifo (
    .clk(clk), .rst(rst), .flush_i(txFlush), .push_i(txWrReq), .pop_i(txPop),
    .data_i(bus_wr_data[DATA_W-1:0]), .head_o(txHead), .full_o(txFull),
    .empty_o(txEmpty), .count_o(txCount)
  );

  MikeUartFifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) rxFifo (
    .clk(clk), .rst(rst), .flush_i(rxFlush), .push_i(rxCapt), .pop_i(rxRdReq),
    .data_i(uart_rx_data), .head_o(rxHead), .full_o(rxFull),
    .empty_o(rxEmpty), .count_o(rxCount)
  );

  // Remember that reset was active so the first cycle after it can clear stale UART flags
  always_ff @(posedge clk) begin
    rstSeen_q <= rst;
  end
  assign startClr = rstSeen_q & ~rst;

  // TX sequencer next state and handshake outputs; a flush in the same cycle blocks a new start
  always_comb begin
    txState_d        = txState_q;
    txPop            = 1'b0;
    uart_tx_send     = 1'b0;
    uart_tx_flag_clr = startClr;
    case (txState_q)
      TX_IDLE: begin
        if (!txEmpty && !txFlush) begin
          txPop     = 1'b1;
          txState_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        uart_tx_send = 1'b1;
        txState_d    = TX_WAIT;
      end
      TX_WAIT: begin
        if (uart_tx_flag) txState_d = TX_CLR;
      end
      TX_CLR: begin
        uart_tx_flag_clr = 1'b1;
        txState_d        = TX_IDLE;
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  // TX state and the character register presented to the transmitter
  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= TX_IDLE;
      txData_q  <= '0;
    end else begin
      txState_q <= txState_d;
      if (txPop) txData_q <= txHead;
    end
  end

  assign uart_tx_data = txData_q;
  assign txBusy       = (txState_q != TX_IDLE);

  // RX sequencer: capture once per flag, then wait for the flag to drop before rearming
  always_comb begin
    rxState_d        = rxState_q;
    rxCapt           = 1'b0;
    uart_rx_flag_clr = startClr;
    case (rxState_q)
      RX_IDLE: begin
        if (uart_rx_flag && !startClr) rxState_d = RX_CAPT;
      end
      RX_CAPT: begin
        rxCapt           = 1'b1;
        uart_rx_flag_clr = 1'b1;
        rxState_d        = RX_DRAIN;
      end
      RX_DRAIN: begin
        if (!uart_rx_flag) rxState_d = RX_IDLE;
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) rxState_q <= RX_IDLE;
    else     rxState_q <= rxState_d;
  end

  assign txOvfSet = txWrReq & txFull & ~txPop;
  assign rxOvfSet = rxCapt & rxFull & ~rxRdReq;
  assign rxUnfSet = rxRdReq & rxEmpty;

  // Sticky error flags; a new event beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      txOvf_q <= 1'b0;
      rxOvf_q <= 1'b0;
      rxUnf_q <= 1'b0;
    end else begin
      txOvf_q <= txOvfSet | (txOvf_q & ~errClr);
      rxOvf_q <= rxOvfSet | (rxOvf_q & ~errClr);
      rxUnf_q <= rxUnfSet | (rxUnf_q & ~errClr);
    end
  end

`ifdef RISC_V_MIKE_UART_IRQ_EN
  logic rxIrqEn_q, txIrqEn_q, irq_q;

  // Interrupt enables persist until rewritten; irq is registered to keep it glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      rxIrqEn_q <= 1'b0;
      txIrqEn_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrlWr) begin
        rxIrqEn_q <= bus_wr_data[3];
        txIrqEn_q <= bus_wr_data[4];
      end
      irq_q <= (rxIrqEn_q & ~rxEmpty) | (txIrqEn_q & txEmpty & ~txBusy);
    end
  end
  assign irq = irq_q;
`endif

  // Status word assembly
  always_comb begin
    statusWord       = '0;
    statusWord[0]    = txFull;
    statusWord[1]    = txEmpty;
    statusWord[2]    = rxFull;
    statusWord[3]    = rxEmpty;
    statusWord[4]    = txBusy;
    statusWord[5]    = txOvf_q;
    statusWord[6]    = rxOvf_q;
    statusWord[7]    = rxUnf_q;
    statusWord[15:8] = 8'(rxCount);
  end

  // Combinational read mux; write-only and unmapped offsets read as zero
  always_comb begin
    bus_rd_data = '0;
    if (bus_rd) begin
      case (wordSel)
        OFF_RXDATA: if (!rxEmpty) bus_rd_data = 32'(rxHead);
        OFF_STATUS: bus_rd_data = statusWord;
`ifdef RISC_V_MIKE_UART_IRQ_EN
        OFF_CTRL:   bus_rd_data = {27'b0, txIrqEn_q, rxIrqEn_q, 3'b0};
`endif
        default:    bus_rd_data = '0;
      endcase
    end
  end

  // txCount is kept for visibility of TX fill level; fold it into the unused sink
  logic unusedTxCount;
  assign unusedTxCount = ^txCount;

endmodule
